// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding request, fixed access latency,
// word read or byte-masked write into an internal array, answered over a response handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam int          CNT_W     = $clog2(LATENCY) + 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               accept;
    logic               mem_wr;
    logic               addr_err;
    logic [IDX_W-1:0]   idx;

    assign idx      = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= MEM_BYTES);

    assign req_ready_o = (state_q == IDLE) && rst_ni;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = addr_err;
                    rdata_d = (addr_err || we_q) ? 32'h0 : mem_q[idx];
                    // Gated by rst_ni so a reset on the RESP-entry edge discards the write.
                    mem_wr  = we_q && !addr_err && rst_ni;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
        end
    end

    // The array is deliberately left out of reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr && wstrb_q[b]) begin
                mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule
